// File: rtl/instr_mem_pkg.sv
// Shared constants and address helpers for the synchronous instruction memory.
package instr_mem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DEPTH  = 4096;
    localparam int unsigned ERR_CNT_W  = 16;

    // True when addr is not word aligned or lies beyond the last word.
    function automatic logic addr_err(input logic [63:0] addr,
                                      input int unsigned depth,
                                      input int unsigned nbytes);
        logic [63:0] limit;
        limit = 64'(depth) * 64'(nbytes);
        return ((addr & (64'(nbytes) - 64'd1)) != 64'd0) || (addr >= limit);
    endfunction

    // Word index taken from the bits just above the byte offset.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input int unsigned wb,
                                               input int unsigned depth);
        return (addr >> wb) & (64'(depth) - 64'd1);
    endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch handshake and write-port bundle for instr_mem_sync.
interface instr_mem_sync_if
    import instr_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_data;
    logic                  resp_err;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  werr;

    modport master (
        output req_valid, req_addr, resp_ready, we, waddr, wdata, wstrb,
        input  req_ready, resp_valid, resp_data, resp_err, werr
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, we, waddr, wdata, wstrb,
        output req_ready, resp_valid, resp_data, resp_err, werr
    );
endinterface

// File: rtl/instr_mem_array.sv
// Word storage with byte-enable writes and a registered read port; never reset.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_strb
);
    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Non-blocking read samples the pre-write word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory with a one-deep fetch response stage, address checks,
// write-error pulse and a saturating error counter.
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_mem_sync_if.slave       bus,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  err_count
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned WB    = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SUM_W = ERR_CNT_W + 1;

    logic [ADDR_W-1:0] req_addr_c;
    logic [ADDR_W-1:0] waddr_c;
    logic              accept_c;
    logic              rerr_c;
    logic              werr_c;
    logic              wr_en_c;
    logic [IDX_W-1:0]  rd_idx_c;
    logic [IDX_W-1:0]  wr_idx_c;
    logic [DATA_W-1:0] rd_data;
    logic [SUM_W-1:0]  err_sum_c;
    logic [ERR_CNT_W-1:0] err_next_c;

    logic resp_valid_q;
    logic resp_err_q;
    logic data_ok_q;
    logic werr_q;

    assign req_addr_c = bus.req_addr;
    assign waddr_c    = bus.waddr;

    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept_c      = bus.req_valid && bus.req_ready;
    assign rerr_c        = addr_err(64'(req_addr_c), DEPTH, NB);
    assign werr_c        = bus.we && (bus.wstrb != '0) && addr_err(64'(waddr_c), DEPTH, NB);
    assign wr_en_c       = bus.we && !werr_c;
    assign rd_idx_c      = IDX_W'(word_index(64'(req_addr_c), WB, DEPTH));
    assign wr_idx_c      = IDX_W'(word_index(64'(waddr_c), WB, DEPTH));

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rd_en   (accept_c && !rerr_c),
        .rd_idx  (rd_idx_c),
        .rd_data (rd_data),
        .wr_en   (wr_en_c),
        .wr_idx  (wr_idx_c),
        .wr_data (bus.wdata),
        .wr_strb (bus.wstrb)
    );

    // Data is gated by a reset flop so it reads zero on reset and on errors.
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_data  = data_ok_q ? rd_data : '0;
    assign bus.werr       = werr_q;

    always_comb begin
        err_sum_c  = SUM_W'(err_count) + SUM_W'(accept_c && rerr_c) + SUM_W'(werr_c);
        err_next_c = err_sum_c[ERR_CNT_W] ? '1 : err_sum_c[ERR_CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            data_ok_q    <= 1'b0;
            werr_q       <= 1'b0;
            err_count    <= '0;
        end else begin
            if (accept_c) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= rerr_c;
                data_ok_q    <= !rerr_c;
            end else if (resp_valid_q && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
                resp_err_q   <= 1'b0;
                data_ok_q    <= 1'b0;
            end
            werr_q    <= werr_c;
            err_count <= err_clr ? '0 : err_next_c;
        end
    end

endmodule
